mmio_timer: RTL and testbench

//   Memory-mapped down-counting timer that answers CPU bus cycles (addr_bus, mem_read, mem_wrt) alongside Memory.

---
 rtl/mmio_timer.sv | 148 ++++++++++++++
 tb/tb_mmio_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with an 8-bit prescaler, auto-reload and a level interrupt.
// Answers single-cycle bus reads/writes inside a 16-byte window; read data is zero when idle.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_bus,
    input  logic [31:0] data_bus_down,
    input  logic        mem_read,
    input  logic        mem_wrt,
    output logic [31:0] data_bus_up,
    output logic        rd_valid,
    output logic        irq
);

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic        ctrl_en;
    logic        ctrl_auto;
    logic        ctrl_irq_en;
    logic [7:0]  ctrl_div;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic        exp_q;
    logic [7:0]  pre_q;

    logic        hit;
    logic        wr_en;
    logic        rd_en;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_count;
    logic        wr_status;
    logic        tick;
    logic        expire;
    logic [31:0] read_val;
    logic        unused_addr_bits;

    // Byte lanes inside a word are not decoded.
    assign unused_addr_bits = ^addr_bus[1:0];

    assign hit       = (addr_bus[31:4] == BASE_ADDR[31:4]);
    assign wr_en     = hit && mem_wrt;
    assign rd_en     = hit && mem_read && !mem_wrt;
    assign wr_ctrl   = wr_en && (addr_bus[3:2] == OFF_CTRL);
    assign wr_load   = wr_en && (addr_bus[3:2] == OFF_LOAD);
    assign wr_count  = wr_en && (addr_bus[3:2] == OFF_COUNT);
    assign wr_status = wr_en && (addr_bus[3:2] == OFF_STATUS);

    assign tick   = ctrl_en && (pre_q == ctrl_div);
    assign expire = tick && (count_q == 32'd0);

    assign irq = exp_q && ctrl_irq_en;

    always_comb begin
        read_val = 32'd0;
        case (addr_bus[3:2])
            OFF_CTRL:   read_val = {16'd0, ctrl_div, 5'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
            OFF_LOAD:   read_val = load_q;
            OFF_COUNT:  read_val = count_q;
            OFF_STATUS: read_val = {31'd0, exp_q};
            default:    read_val = 32'd0;
        endcase
    end

    // A CTRL write clears the prescaler so a new DIV starts from a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= 8'd0;
        end else if (wr_ctrl || !ctrl_en || tick) begin
            pre_q <= 8'd0;
        end else begin
            pre_q <= pre_q + 8'd1;
        end
    end

    // A CTRL write overrides the one-shot auto-stop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_div    <= 8'd0;
        end else if (wr_ctrl) begin
            ctrl_en     <= data_bus_down[0];
            ctrl_auto   <= data_bus_down[1];
            ctrl_irq_en <= data_bus_down[2];
            ctrl_div    <= data_bus_down[15:8];
        end else if (expire && !ctrl_auto) begin
            ctrl_en <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q <= RESET_LOAD;
        end else if (wr_load) begin
            load_q <= data_bus_down;
        end
    end

    // Reload uses the LOAD value from before this edge; a bus write to COUNT wins over the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RESET_LOAD;
        end else if (wr_count) begin
            count_q <= data_bus_down;
        end else if (tick) begin
            if (count_q != 32'd0) begin
                count_q <= count_q - 32'd1;
            end else if (ctrl_auto) begin
                count_q <= load_q;
            end
        end
    end

    // Hardware expiry wins over a write-1-to-clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= 1'b0;
        end else if (expire) begin
            exp_q <= 1'b1;
        end else if (wr_status && data_bus_down[0]) begin
            exp_q <= 1'b0;
        end
    end

    // Response: rd_valid is high for exactly the one cycle after an accepted read and carries
    // the register value seen before that edge; there is no ready, the CPU must take it then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_bus_up <= 32'd0;
            rd_valid    <= 1'b0;
        end else if (rd_en) begin
            data_bus_up <= read_val;
            rd_valid    <= 1'b1;
        end else begin
            data_bus_up <= 32'd0;
            rd_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer: register access, prescaler timing,
// one-shot/auto-reload expiry, same-cycle priorities, decode misses and async reset.
module tb_mmio_timer;

    localparam logic [31:0] BASE       = 32'hFFFF_0000;
    localparam logic [31:0] A_CTRL     = BASE + 32'h0;
    localparam logic [31:0] A_LOAD     = BASE + 32'h4;
    localparam logic [31:0] A_COUNT    = BASE + 32'h8;
    localparam logic [31:0] A_STATUS   = BASE + 32'hC;

    logic        clk;
    logic        rst;
    logic [31:0] addr_bus;
    logic [31:0] data_bus_down;
    logic        mem_read;
    logic        mem_wrt;
    logic [31:0] data_bus_up;
    logic        rd_valid;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mmio_timer #(
        .BASE_ADDR (BASE),
        .RESET_LOAD(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_bus     (addr_bus),
        .data_bus_down(data_bus_down),
        .mem_read     (mem_read),
        .mem_wrt      (mem_wrt),
        .data_bus_up  (data_bus_up),
        .rd_valid     (rd_valid),
        .irq          (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    // driver tasks: inputs change #1 after a posedge and are sampled at the next posedge
    task automatic tick_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr_bus      = a;
        data_bus_down = d;
        mem_wrt       = 1'b1;
        tick_wait(1);
        mem_wrt       = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        addr_bus = a;
        mem_read = 1'b1;
        tick_wait(1);
        mem_read = 1'b0;
        d = data_bus_up;
        v = rd_valid;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] want);
        logic [31:0] d;
        logic        v;
        do_read(a, d, v);
        check({tag, "_valid"}, {31'd0, v}, 32'd1);
        check(tag, d, want);
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        logic [31:0] e;

        rst           = 1'b1;
        addr_bus      = 32'd0;
        data_bus_down = 32'd0;
        mem_read      = 1'b0;
        mem_wrt       = 1'b0;
        tick_wait(2);
        rst = 1'b0;
        tick_wait(1);

        // 1: reset values
        check("idle_valid", {31'd0, rd_valid}, 32'd0);
        check("idle_data", data_bus_up, 32'd0);
        read_check("rst_ctrl", A_CTRL, 32'd0);
        read_check("rst_load", A_LOAD, 32'd0);
        read_check("rst_count", A_COUNT, 32'd0);
        read_check("rst_status", A_STATUS, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        tick_wait(1);
        check("idle_after_read_valid", {31'd0, rd_valid}, 32'd0);

        // 2: auto-reload, DIV=0, back-to-back COUNT reads
        do_write(A_LOAD, 32'd3);
        do_write(A_COUNT, 32'd3);
        do_write(A_CTRL, 32'h0000_0007);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd3);
        addr_bus = A_COUNT;
        mem_read = 1'b1;
        while (exp_q.size() > 0) begin
            tick_wait(1);
            e = exp_q.pop_front();
            check("auto_stream_valid", {31'd0, rd_valid}, 32'd1);
            check("auto_stream_count", data_bus_up, e);
        end
        mem_read = 1'b0;
        check("auto_irq", {31'd0, irq}, 32'd1);
        do_write(A_CTRL, 32'd0);
        check("write_no_valid", {31'd0, rd_valid}, 32'd0);
        read_check("auto_status", A_STATUS, 32'd1);

        // 3: one-shot with DIV=4, expiry on the 15th clock after enable
        do_write(A_STATUS, 32'd1);
        do_write(A_COUNT, 32'd2);
        do_write(A_CTRL, 32'h0000_0401);
        tick_wait(13);
        addr_bus = A_STATUS;
        mem_read = 1'b1;
        tick_wait(1);
        check("div_exp_e14", data_bus_up, 32'd0);
        tick_wait(1);
        check("div_exp_e15", data_bus_up, 32'd0);
        tick_wait(1);
        check("div_exp_e16", data_bus_up, 32'd1);
        mem_read = 1'b0;
        check("div_irq_masked", {31'd0, irq}, 32'd0);
        read_check("oneshot_ctrl", A_CTRL, 32'h0000_0400);
        read_check("oneshot_count", A_COUNT, 32'd0);

        // 4: W1C collides with expiry, then a clean W1C
        do_write(A_STATUS, 32'd1);
        read_check("w1c_pre", A_STATUS, 32'd0);
        do_write(A_COUNT, 32'd0);
        do_write(A_CTRL, 32'h0000_0005);
        do_write(A_STATUS, 32'd1);
        read_check("w1c_collide", A_STATUS, 32'd1);
        check("w1c_collide_irq", {31'd0, irq}, 32'd1);
        read_check("w1c_ctrl", A_CTRL, 32'h0000_0004);
        do_write(A_STATUS, 32'd1);
        read_check("w1c_clean", A_STATUS, 32'd0);
        check("w1c_clean_irq", {31'd0, irq}, 32'd0);

        // CTRL write in the same cycle as an auto-stop keeps EN
        do_write(A_CTRL, 32'h0000_0001);
        do_write(A_CTRL, 32'h0000_0001);
        read_check("ctrl_wins", A_CTRL, 32'h0000_0001);
        read_check("ctrl_stop_later", A_CTRL, 32'h0000_0000);
        do_write(A_STATUS, 32'd1);

        // 5: COUNT write wins over a same-cycle tick
        do_write(A_COUNT, 32'd100);
        do_write(A_CTRL, 32'h0000_0001);
        do_write(A_COUNT, 32'h0000_0010);
        read_check("count_wins", A_COUNT, 32'h0000_0010);
        do_write(A_CTRL, 32'd0);
        read_check("count_after", A_COUNT, 32'h0000_000E);

        // read and write together: write only
        addr_bus      = A_COUNT;
        data_bus_down = 32'h0000_0055;
        mem_read      = 1'b1;
        mem_wrt       = 1'b1;
        tick_wait(1);
        mem_read = 1'b0;
        mem_wrt  = 1'b0;
        check("rw_valid", {31'd0, rd_valid}, 32'd0);
        check("rw_data", data_bus_up, 32'd0);
        read_check("rw_written", A_COUNT, 32'h0000_0055);

        // outside the window
        do_write(BASE + 32'h20, 32'h0000_0007);
        do_read(BASE + 32'h20, d, v);
        check("miss_valid", {31'd0, v}, 32'd0);
        check("miss_data", d, 32'd0);
        read_check("miss_ctrl", A_CTRL, 32'd0);
        read_check("miss_count", A_COUNT, 32'h0000_0055);

        // 6: asynchronous reset with a response on the bus
        do_write(A_COUNT, 32'h0000_1000);
        do_write(A_CTRL, 32'h0000_0001);
        addr_bus = A_COUNT;
        mem_read = 1'b1;
        tick_wait(1);
        mem_read = 1'b0;
        check("inflight_valid", {31'd0, rd_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, rd_valid}, 32'd0);
        check("arst_data", data_bus_up, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        tick_wait(1);
        rst = 1'b0;
        read_check("arst_ctrl", A_CTRL, 32'd0);
        read_check("arst_load", A_LOAD, 32'd0);
        read_check("arst_count", A_COUNT, 32'd0);
        read_check("arst_status", A_STATUS, 32'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
